// File: rtl/operand_sel_pipe_pkg.sv
// Shared definitions for the ALU B-operand selector: skid FSM state encoding and
// datapath source index constants used by control logic that drives sel.
package operand_sel_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // B-operand source slots in the datapath mux.
  localparam int SRC_B        = 0;
  localparam int SRC_EXT      = 1;
  localparam int SRC_FOUR     = 2;
  localparam int SRC_ONE      = 3;
  localparam int SRC_EXT_SHL2 = 4;

endpackage

// File: rtl/operand_sel_pipe_if.sv
// Handshake bundle between the operand producer/consumer and operand_sel_pipe.
// A beat moves on a clock edge where valid & ready are both 1; the sender keeps its
// payload stable and valid asserted until that happens, and ready never depends
// combinationally on valid.
interface operand_sel_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_SRC   = 5,
  parameter int SEL_W     = 3,
  parameter int ERR_CNT_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_bus;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     out_err;
  logic [ERR_CNT_W-1:0]     err_count;

  modport master (
    output in_valid, sel, src_bus, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_err, err_count
  );

  modport slave (
    input  in_valid, sel, src_bus, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_err, err_count
  );
endinterface

// File: rtl/operand_sel_pipe_mux.sv
// Combinational NUM_SRC:1 operand select; out-of-range selects fall back to
// DEFAULT_SRC and raise o_err so no undefined slice is ever read.
module operand_mux_n #(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 5,
  parameter int SEL_W       = 3,
  parameter int DEFAULT_SRC = 0
) (
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [NUM_SRC*WIDTH-1:0] i_src_bus,
  output logic [WIDTH-1:0]         o_data,
  output logic [SEL_W-1:0]         o_sel,
  output logic                     o_err
);

  logic             w_err;
  logic [SEL_W-1:0] w_used_sel;

  assign w_err      = (int'(i_sel) >= NUM_SRC);
  assign w_used_sel = w_err ? SEL_W'(DEFAULT_SRC) : i_sel;

  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(w_used_sel) == k) o_data = i_src_bus[k*WIDTH +: WIDTH];
    end
  end

  assign o_sel = w_used_sel;
  assign o_err = w_err;

endmodule

// File: rtl/operand_sel_pipe.sv
// Registered operand selector: mux result lands in a 2-entry skid buffer (main M,
// skid S) so output stalls never drop a beat; counts substituted out-of-range beats.
module operand_sel_pipe
  import operand_sel_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_SRC     = 5,
  parameter int SEL_W       = 3,
  parameter int DEFAULT_SRC = 0,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  operand_sel_pipe_if.slave    bus,
  output state_t               o_dbg_state
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0]     w_mux_data;
  logic [SEL_W-1:0]     w_mux_sel;
  logic                 w_mux_err;
  logic                 w_accept;
  logic                 w_xfer;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_m_data;
  logic [SEL_W-1:0]     r_m_sel;
  logic                 r_m_err;
  logic [WIDTH-1:0]     r_s_data;
  logic [SEL_W-1:0]     r_s_sel;
  logic                 r_s_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  operand_mux_n #(
    .WIDTH      (WIDTH),
    .NUM_SRC    (NUM_SRC),
    .SEL_W      (SEL_W),
    .DEFAULT_SRC(DEFAULT_SRC)
  ) u_mux (
    .i_sel    (bus.sel),
    .i_src_bus(bus.src_bus),
    .o_data   (w_mux_data),
    .o_sel    (w_mux_sel),
    .o_err    (w_mux_err)
  );

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_xfer   = r_out_valid & bus.out_ready;

  // in_ready is registered from the next state, so it only drops once S is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_m_data    <= '0;
      r_m_sel     <= '0;
      r_m_err     <= 1'b0;
      r_s_data    <= '0;
      r_s_sel     <= '0;
      r_s_err     <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept && w_mux_err && (r_err_count != ERR_MAX))
        r_err_count <= r_err_count + 1'b1;
      r_in_ready <= 1'b1;
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_data    <= w_mux_data;
            r_m_sel     <= w_mux_sel;
            r_m_err     <= w_mux_err;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_xfer) begin
            r_m_data <= w_mux_data;
            r_m_sel  <= w_mux_sel;
            r_m_err  <= w_mux_err;
          end else if (w_accept) begin
            r_s_data   <= w_mux_data;
            r_s_sel    <= w_mux_sel;
            r_s_err    <= w_mux_err;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_xfer) begin
            r_m_data <= r_s_data;
            r_m_sel  <= r_s_sel;
            r_m_err  <= r_s_err;
            r_state  <= ST_ONE;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_m_data;
  assign bus.out_sel   = r_m_sel;
  assign bus.out_err   = r_m_err;
  assign bus.err_count = r_err_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Bench for operand_sel_pipe: a queue-based reference of the 2-deep buffer checks every
// delivered beat; scenario tasks add targeted checks, plus a 16-bit/8-source instance.
module tb_operand_sel_pipe;
  import operand_sel_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  sel;
    logic        err;
  } beat_t;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg0;
  state_t dbg1;

  always #5 clk = ~clk;

  operand_sel_pipe_if #(.WIDTH(32), .NUM_SRC(5), .SEL_W(3), .ERR_CNT_W(8)) bus5 ();
  operand_sel_pipe_if #(.WIDTH(16), .NUM_SRC(8), .SEL_W(3), .ERR_CNT_W(8)) bus8 ();

  operand_sel_pipe #(.WIDTH(32), .NUM_SRC(5), .SEL_W(3), .DEFAULT_SRC(0), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus5), .o_dbg_state(dbg0)
  );

  operand_sel_pipe #(.WIDTH(16), .NUM_SRC(8), .SEL_W(3), .DEFAULT_SRC(0), .ERR_CNT_W(8)) dut_w (
    .clk(clk), .reset(reset), .bus(bus8), .o_dbg_state(dbg1)
  );

  // Reference model: beats accepted but not yet taken, in order.
  logic [31:0] src[5];
  beat_t       exp_q[$];
  int          m_err_cnt;
  bit          m_rdy;
  bit          sb_en;
  int          n_checks;
  int          n_pass;

  function automatic beat_t model_pick(input logic [2:0] s);
    beat_t b;
    if (int'(s) < 5) b = '{data: src[s], sel: s, err: 1'b0};
    else             b = '{data: src[0], sel: 3'd0, err: 1'b1};
    return b;
  endfunction

  task automatic drive_in(input logic v, input logic [2:0] s);
    bus5.in_valid = v;
    bus5.sel      = s;
    for (int k = 0; k < 5; k++) bus5.src_bus[k*32 +: 32] = src[k];
  endtask

  task automatic randomize_src();
    for (int k = 0; k < 5; k++) src[k] = $urandom;
  endtask

  // One clock: update the model with what the edge sees, then return at the falling edge.
  task automatic tick();
    bit acc;
    bit xfer;
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      m_err_cnt = 0;
      m_rdy     = 1'b0;
    end else begin
      acc  = bus5.in_valid && m_rdy && (exp_q.size() < 2);
      xfer = bus5.out_ready && (exp_q.size() > 0);
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(model_pick(bus5.sel));
        if (int'(bus5.sel) >= 5 && m_err_cnt < 255) m_err_cnt++;
      end
      m_rdy = 1'b1;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sb_en) begin
      n_checks++;
      if (bus5.out_valid !== (exp_q.size() > 0))
        $display("FAIL sb_valid: got %b want %b", bus5.out_valid, exp_q.size() > 0);
      else n_pass++;
      if (exp_q.size() > 0) begin
        n_checks++;
        if ({bus5.out_data, bus5.out_sel, bus5.out_err} !== exp_q[0])
          $display("FAIL sb_beat: got %h/%0d/%b want %h/%0d/%b", bus5.out_data, bus5.out_sel,
                   bus5.out_err, exp_q[0].data, exp_q[0].sel, exp_q[0].err);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    drive_in(1'b0, 3'd0);
    bus5.out_ready = 1'b0;
    tick();
    tick();
    sb_en = 1'b1;
    n_checks++;
    if ({bus5.out_valid, bus5.out_data, bus5.out_sel, bus5.out_err, bus5.err_count, bus5.in_ready} !== '0)
      $display("FAIL reset_state: got v=%b d=%h s=%0d e=%b c=%0d r=%b want all 0", bus5.out_valid,
               bus5.out_data, bus5.out_sel, bus5.out_err, bus5.err_count, bus5.in_ready);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus5.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus5.in_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    randomize_src();
    src[1] = 32'h0000_00AA;
    bus5.out_ready = 1'b1;
    drive_in(1'b1, 3'd1);
    tick();
    drive_in(1'b0, 3'd0);
    n_checks++;
    if ({bus5.out_valid, bus5.out_data, bus5.out_sel, bus5.out_err} !== {1'b1, 32'hAA, 3'd1, 1'b0})
      $display("FAIL single: got v=%b d=%h s=%0d e=%b want 1/aa/1/0", bus5.out_valid,
               bus5.out_data, bus5.out_sel, bus5.out_err);
    else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    randomize_src();
    bus5.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, 3'(i));
      tick();
      n_checks++;
      if (bus5.out_data !== src[i] || bus5.in_ready !== 1'b1)
        $display("FAIL stream_%0d: got d=%h r=%b want d=%h r=1", i, bus5.out_data, bus5.in_ready, src[i]);
      else n_pass++;
    end
    drive_in(1'b0, 3'd0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    logic [31:0] b;
    randomize_src();
    a = src[2];
    b = src[3];
    bus5.out_ready = 1'b0;
    drive_in(1'b1, 3'd2);
    tick();
    drive_in(1'b1, 3'd3);
    tick();
    drive_in(1'b0, 3'd0);
    randomize_src();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bus5.in_ready !== 1'b0 || bus5.out_data !== a)
        $display("FAIL bp_hold_%0d: got r=%b d=%h want r=0 d=%h", i, bus5.in_ready, bus5.out_data, a);
      else n_pass++;
      tick();
    end
    bus5.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus5.out_data !== b || bus5.in_ready !== 1'b1)
      $display("FAIL bp_second: got d=%h r=%b want d=%h r=1", bus5.out_data, bus5.in_ready, b);
    else n_pass++;
    tick();
    n_checks++;
    if (bus5.out_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", bus5.out_valid);
    else n_pass++;
  endtask

  task automatic test_err_saturate();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    randomize_src();
    src[0] = 32'h1234;
    bus5.out_ready = 1'b1;
    drive_in(1'b1, 3'd7);
    tick();
    n_checks++;
    if ({bus5.out_data, bus5.out_sel, bus5.out_err} !== {32'h1234, 3'd0, 1'b1} || bus5.err_count !== 8'd1)
      $display("FAIL err_first: got d=%h s=%0d e=%b c=%0d want 1234/0/1/1", bus5.out_data,
               bus5.out_sel, bus5.out_err, bus5.err_count);
    else n_pass++;
    for (int i = 1; i < 300; i++) begin
      drive_in(1'b1, 3'($urandom_range(5, 7)));
      tick();
    end
    drive_in(1'b0, 3'd0);
    tick();
    n_checks++;
    if (bus5.err_count !== 8'd255) $display("FAIL err_sat: got %0d want 255", bus5.err_count);
    else n_pass++;
  endtask

  task automatic test_reset_in_full();
    randomize_src();
    bus5.out_ready = 1'b0;
    drive_in(1'b1, 3'd7);
    tick();
    drive_in(1'b1, 3'd4);
    tick();
    n_checks++;
    if (bus5.in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus5.in_ready);
    else n_pass++;
    reset = 1'b1;
    bus5.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus5.out_valid !== 1'b0 || bus5.err_count !== 8'd0 || bus5.in_ready !== 1'b0)
      $display("FAIL rst_full: got v=%b c=%0d r=%b want 0/0/0", bus5.out_valid, bus5.err_count, bus5.in_ready);
    else n_pass++;
    reset = 1'b0;
    drive_in(1'b0, 3'd0);
    tick();
    n_checks++;
    if (bus5.in_ready !== 1'b1) $display("FAIL rst_full_ready: got %b want 1", bus5.in_ready);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      randomize_src();
      drive_in(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      bus5.out_ready = ($urandom_range(0, 3) != 0);
      n_checks++;
      if (bus5.in_ready !== (exp_q.size() < 2) || bus5.err_count !== 8'(m_err_cnt))
        $display("FAIL rand_%0d: got r=%b c=%0d want r=%b c=%0d", i, bus5.in_ready,
                 bus5.err_count, exp_q.size() < 2, m_err_cnt);
      else n_pass++;
      tick();
    end
    drive_in(1'b0, 3'd0);
    bus5.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_wide();
    logic [15:0] w_src[8];
    for (int k = 0; k < 8; k++) begin
      w_src[k] = 16'($urandom);
      bus8.src_bus[k*16 +: 16] = w_src[k];
    end
    bus8.out_ready = 1'b1;
    for (int s = 7; s >= 0; s--) begin
      bus8.in_valid = 1'b1;
      bus8.sel      = 3'(s);
      tick();
      n_checks++;
      if ({bus8.out_valid, bus8.out_data, bus8.out_sel, bus8.out_err} !== {1'b1, w_src[s], 3'(s), 1'b0})
        $display("FAIL wide_sel%0d: got v=%b d=%h s=%0d e=%b want 1/%h/%0d/0", s, bus8.out_valid,
                 bus8.out_data, bus8.out_sel, bus8.out_err, w_src[s], s);
      else n_pass++;
    end
    bus8.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    sb_en     = 1'b0;
    m_err_cnt = 0;
    m_rdy     = 1'b0;
    reset     = 1'b1;
    for (int k = 0; k < 5; k++) src[k] = '0;
    drive_in(1'b0, 3'd0);
    bus5.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.sel       = '0;
    bus8.src_bus   = '0;
    bus8.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_err_saturate();
    test_reset_in_full();
    test_random();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
